if_fetch_unit: RTL and testbench

Instruction-fetch stage controller that produces the instruction stream consumed by the IF/ID pipeline register. It owns the program counter and runs the instruction-memory read handshake (READ/BUSYWAIT). It buffers a fetched instruction while the decode stage is stalled, and handles branch redirects, including redirects that arrive while a memory miss is still outstanding. Its IF_PC, IF_INSTRUCTION and HOLD outputs connect directly to the IF/ID register inputs of the same names.

---
 rtl/if_fetch_unit_pkg.sv | 26 ++
 rtl/if_fetch_unit_next_pc.sv | 23 ++
 rtl/if_fetch_unit.sv | 109 ++++++++++
 tb/tb_if_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared CPU definitions for the instruction-fetch stage: state encoding,
// next-PC selection codes, bubble encoding and reset vector.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HELD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    NPC_KEEP    = 2'd0,
    NPC_SEQ     = 2'd1,
    NPC_BRANCH  = 2'd2,
    NPC_PENDING = 2'd3
  } next_pc_sel_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  // Instruction addresses are word aligned; the low two bits of any target are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_unit_next_pc.sv
// Next-PC mux for the fetch stage: sequential, immediate redirect, or the
// redirect that was parked behind an outstanding miss.
module if_fetch_unit_next_pc
  import if_fetch_unit_pkg::*;
(
  input  logic [31:0]  pc,
  input  logic [31:0]  branch_target,
  input  logic [31:0]  pending_target,
  input  next_pc_sel_t sel,
  output logic [31:0]  next_pc
);

  always_comb begin
    next_pc = pc;
    case (sel)
      NPC_SEQ:     next_pc = pc + 32'd4;
      NPC_BRANCH:  next_pc = align_word(branch_target);
      NPC_PENDING: next_pc = pending_target;
      default:     next_pc = pc;
    endcase
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch controller: owns the PC, runs the IMEM READ/BUSYWAIT
// handshake, buffers an instruction across decode stalls and handles redirects.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_READ,
  input  logic        IMEM_BUSYWAIT,
  input  logic [31:0] IMEM_INSTR,
  input  logic        STALL_IN,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_INSTRUCTION,
  output logic        HOLD
);

  fetch_state_t state;
  logic [31:0]  pc_q;
  logic [31:0]  buf_q;
  logic [31:0]  tgt_q;
  logic [31:0]  next_pc;
  next_pc_sel_t npc_sel;

  assign IMEM_ADDR = pc_q;
  assign IF_PC     = pc_q;

  if_fetch_unit_next_pc u_next_pc (
    .pc             (pc_q),
    .branch_target  (BRANCH_TARGET),
    .pending_target (tgt_q),
    .sel            (npc_sel),
    .next_pc        (next_pc)
  );

  // Outputs and the PC update choice are combinational from state plus inputs.
  always_comb begin
    IMEM_READ      = 1'b0;
    IF_INSTRUCTION = NOP_INSTR;
    HOLD           = 1'b0;
    npc_sel        = NPC_KEEP;
    if (!RESET) begin
      case (state)
        FETCH: begin
          IMEM_READ = 1'b1;
          HOLD      = STALL_IN & ~BRANCH_TAKEN;
          if (BRANCH_TAKEN) begin
            npc_sel = IMEM_BUSYWAIT ? NPC_KEEP : NPC_BRANCH;
          end else if (!IMEM_BUSYWAIT) begin
            IF_INSTRUCTION = IMEM_INSTR;
            if (!STALL_IN) npc_sel = NPC_SEQ;
          end
        end
        HELD: begin
          HOLD = STALL_IN & ~BRANCH_TAKEN;
          if (BRANCH_TAKEN) begin
            npc_sel = NPC_BRANCH;
          end else begin
            IF_INSTRUCTION = buf_q;
            if (!STALL_IN) npc_sel = NPC_SEQ;
          end
        end
        DRAIN: begin
          // The miss cannot be aborted, so the old address stays on the bus until it completes.
          IMEM_READ = 1'b1;
          if (!IMEM_BUSYWAIT) npc_sel = BRANCH_TAKEN ? NPC_BRANCH : NPC_PENDING;
        end
        default: begin
          IMEM_READ = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= FETCH;
      pc_q  <= RESET_PC;
      buf_q <= 32'd0;
      tgt_q <= 32'd0;
    end else begin
      if (npc_sel != NPC_KEEP) pc_q <= next_pc;
      case (state)
        FETCH: begin
          if (BRANCH_TAKEN) begin
            if (IMEM_BUSYWAIT) begin
              tgt_q <= align_word(BRANCH_TARGET);
              state <= DRAIN;
            end
          end else if (!IMEM_BUSYWAIT && STALL_IN) begin
            buf_q <= IMEM_INSTR;
            state <= HELD;
          end
        end
        HELD: begin
          if (BRANCH_TAKEN || !STALL_IN) state <= FETCH;
        end
        DRAIN: begin
          if (BRANCH_TAKEN) tgt_q <= align_word(BRANCH_TARGET);
          if (!IMEM_BUSYWAIT) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, a hand-written redirect
// sequence, then randomized traffic against a queue-based reference model.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] MEM_KEY = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_read;
  logic        imem_busywait;
  logic [31:0] imem_instr;
  logic        stall_in;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;
  logic        hold;

  int checks;
  int failures;

  if_fetch_unit dut (
    .CLK            (clk),
    .RESET          (reset),
    .IMEM_ADDR      (imem_addr),
    .IMEM_READ      (imem_read),
    .IMEM_BUSYWAIT  (imem_busywait),
    .IMEM_INSTR     (imem_instr),
    .STALL_IN       (stall_in),
    .BRANCH_TAKEN   (branch_taken),
    .BRANCH_TARGET  (branch_target),
    .IF_PC          (if_pc),
    .IF_INSTRUCTION (if_instruction),
    .HOLD           (hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: the word at any address is the address XOR a fixed key.
  assign imem_instr = imem_addr ^ MEM_KEY;

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    return a ^ MEM_KEY;
  endfunction

  typedef struct {
    string       name;
    bit          rst;
    bit          stall;
    bit          bt;
    logic [31:0] tgt;
    bit          busy;
    bit          chk_pc;
    logic [31:0] pc;
    bit          rd;
    logic [31:0] ins;
    bit          hld;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input bit rst, input bit stall, input bit bt,
                              input logic [31:0] tgt, input bit busy, input bit chk_pc,
                              input logic [31:0] pc, input bit rd, input logic [31:0] ins,
                              input bit hld);
    vec_t v;
    v.name = n; v.rst = rst; v.stall = stall; v.bt = bt; v.tgt = tgt; v.busy = busy;
    v.chk_pc = chk_pc; v.pc = pc; v.rd = rd; v.ins = ins; v.hld = hld;
    return v;
  endfunction

  task automatic applyStimulus(input bit rst, input bit stall, input bit bt,
                               input logic [31:0] tgt, input bit busy);
    @(negedge clk);
    reset         = rst;
    stall_in      = stall;
    branch_taken  = bt;
    branch_target = tgt;
    imem_busywait = busy;
    #1;
  endtask

  task automatic checkOutput(input string n, input bit chk_pc, input logic [31:0] e_pc,
                             input bit e_rd, input logic [31:0] e_ins, input bit e_hld);
    if (chk_pc) begin
      checks++;
      if (if_pc !== e_pc) begin
        failures++;
        $display("[TB] FAIL %s if_pc: got %h expected %h", n, if_pc, e_pc);
      end
      checks++;
      if (imem_addr !== e_pc) begin
        failures++;
        $display("[TB] FAIL %s imem_addr: got %h expected %h", n, imem_addr, e_pc);
      end
    end
    checks++;
    if (imem_read !== e_rd) begin
      failures++;
      $display("[TB] FAIL %s imem_read: got %b expected %b", n, imem_read, e_rd);
    end
    checks++;
    if (if_instruction !== e_ins) begin
      failures++;
      $display("[TB] FAIL %s if_instruction: got %h expected %h", n, if_instruction, e_ins);
    end
    checks++;
    if (hold !== e_hld) begin
      failures++;
      $display("[TB] FAIL %s hold: got %b expected %b", n, hold, e_hld);
    end
  endtask

  // Reference model: a PC, a queue holding the stalled instruction and a queue
  // holding the redirect waiting for an in-flight miss to finish.
  logic [31:0] m_pc;
  bit          m_pc_known;
  logic [31:0] held_q[$];
  logic [31:0] pending_q[$];

  task automatic ref_step(input bit rst, input bit stall, input bit bt, input logic [31:0] tgt,
                          input bit busy, output bit e_chk, output logic [31:0] e_pc,
                          output bit e_rd, output logic [31:0] e_ins, output bit e_hld);
    logic [31:0] aligned;
    aligned = {tgt[31:2], 2'b00};
    e_chk = m_pc_known;
    e_pc  = m_pc;
    e_rd  = 1'b0;
    e_ins = NOP;
    e_hld = 1'b0;
    if (rst) begin
      m_pc = 32'd0;
      m_pc_known = 1'b1;
      held_q.delete();
      pending_q.delete();
    end else if (pending_q.size() > 0) begin
      e_rd = 1'b1;
      if (bt) pending_q[0] = aligned;
      if (!busy) begin
        m_pc = pending_q[0];
        pending_q.delete();
      end
    end else if (held_q.size() > 0) begin
      e_hld = stall && !bt;
      if (bt) begin
        m_pc = aligned;
        held_q.delete();
      end else begin
        e_ins = held_q[0];
        if (!stall) begin
          void'(held_q.pop_front());
          m_pc = m_pc + 32'd4;
        end
      end
    end else begin
      e_rd  = 1'b1;
      e_hld = stall && !bt;
      if (bt) begin
        if (busy) pending_q.push_back(aligned);
        else m_pc = aligned;
      end else if (!busy) begin
        e_ins = instr_at(m_pc);
        if (stall) held_q.push_back(e_ins);
        else m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    bit          e_chk;
    logic [31:0] e_pc;
    bit          e_rd;
    logic [31:0] e_ins;
    bit          e_hld;
    bit          r_rst, r_stall, r_bt, r_busy;
    logic [31:0] r_tgt;

    checks = 0;
    failures = 0;
    m_pc = 32'd0;
    m_pc_known = 1'b0;
    reset = 1'b1;
    stall_in = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'd0;
    imem_busywait = 1'b0;

    //            name         rst st bt tgt           bz chk pc            rd ins                  hold
    vecs.push_back(mk("rst0",     1, 0, 0, 32'h0,        0, 0, 32'h0,        0, NOP,                 0));
    vecs.push_back(mk("rst1",     1, 0, 0, 32'h0,        0, 1, 32'h0,        0, NOP,                 0));
    vecs.push_back(mk("seq0",     0, 0, 0, 32'h0,        0, 1, 32'h0,        1, instr_at(32'h0),     0));
    vecs.push_back(mk("seq4",     0, 0, 0, 32'h0,        0, 1, 32'h4,        1, instr_at(32'h4),     0));
    vecs.push_back(mk("seq8",     0, 0, 0, 32'h0,        0, 1, 32'h8,        1, instr_at(32'h8),     0));
    vecs.push_back(mk("seq12",    0, 0, 0, 32'h0,        0, 1, 32'hC,        1, instr_at(32'hC),     0));
    vecs.push_back(mk("br_to8",   0, 0, 1, 32'h8,        0, 1, 32'h10,       1, NOP,                 0));
    vecs.push_back(mk("miss8a",   0, 0, 0, 32'h0,        1, 1, 32'h8,        1, NOP,                 0));
    vecs.push_back(mk("miss8b",   0, 0, 0, 32'h0,        1, 1, 32'h8,        1, NOP,                 0));
    vecs.push_back(mk("miss8c",   0, 0, 0, 32'h0,        1, 1, 32'h8,        1, NOP,                 0));
    vecs.push_back(mk("miss8d",   0, 0, 0, 32'h0,        0, 1, 32'h8,        1, instr_at(32'h8),     0));
    vecs.push_back(mk("br_to4",   0, 0, 1, 32'h4,        0, 1, 32'hC,        1, NOP,                 0));
    vecs.push_back(mk("stallhit", 0, 1, 0, 32'h0,        0, 1, 32'h4,        1, instr_at(32'h4),     1));
    vecs.push_back(mk("held",     0, 1, 0, 32'h0,        0, 1, 32'h4,        0, instr_at(32'h4),     1));
    vecs.push_back(mk("release",  0, 0, 0, 32'h0,        0, 1, 32'h4,        0, instr_at(32'h4),     0));
    vecs.push_back(mk("after8",   0, 0, 0, 32'h0,        0, 1, 32'h8,        1, instr_at(32'h8),     0));
    vecs.push_back(mk("br_to20",  0, 0, 1, 32'h20,       0, 1, 32'hC,        1, NOP,                 0));
    vecs.push_back(mk("m20a",     0, 0, 0, 32'h0,        1, 1, 32'h20,       1, NOP,                 0));
    vecs.push_back(mk("m20br",    0, 0, 1, 32'h103,      1, 1, 32'h20,       1, NOP,                 0));
    vecs.push_back(mk("drain_c",  0, 0, 0, 32'h0,        1, 1, 32'h20,       1, NOP,                 0));
    vecs.push_back(mk("drain_d",  0, 0, 0, 32'h0,        1, 1, 32'h20,       1, NOP,                 0));
    vecs.push_back(mk("drain_e",  0, 0, 0, 32'h0,        0, 1, 32'h20,       1, NOP,                 0));
    vecs.push_back(mk("tgt100",   0, 0, 0, 32'h0,        0, 1, 32'h100,      1, instr_at(32'h100),   0));
    vecs.push_back(mk("st104",    0, 1, 0, 32'h0,        0, 1, 32'h104,      1, instr_at(32'h104),   1));
    vecs.push_back(mk("heldbr",   0, 1, 1, 32'h40,       0, 1, 32'h104,      0, NOP,                 0));
    vecs.push_back(mk("tgt40",    0, 0, 0, 32'h0,        0, 1, 32'h40,       1, instr_at(32'h40),    0));
    vecs.push_back(mk("br_top",   0, 0, 1, 32'hFFFFFFFF, 0, 1, 32'h44,       1, NOP,                 0));
    vecs.push_back(mk("top",      0, 0, 0, 32'h0,        0, 1, 32'hFFFFFFFC, 1, instr_at(32'hFFFFFFFC), 0));
    vecs.push_back(mk("wrap0",    0, 0, 0, 32'h0,        0, 1, 32'h0,        1, instr_at(32'h0),     0));
    vecs.push_back(mk("miss4",    0, 0, 0, 32'h0,        1, 1, 32'h4,        1, NOP,                 0));
    vecs.push_back(mk("rstmiss",  1, 0, 0, 32'h0,        1, 1, 32'h4,        0, NOP,                 0));
    vecs.push_back(mk("postrst",  0, 0, 0, 32'h0,        0, 1, 32'h0,        1, instr_at(32'h0),     0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].stall, vecs[i].bt, vecs[i].tgt, vecs[i].busy);
      checkOutput(vecs[i].name, vecs[i].chk_pc, vecs[i].pc, vecs[i].rd, vecs[i].ins, vecs[i].hld);
    end

    // Two redirects during one miss at 0x4: the later one must win.
    applyStimulus(0, 0, 1, 32'h200, 1);
    checkOutput("latest_a", 1, 32'h4, 1, NOP, 0);
    applyStimulus(0, 0, 1, 32'h300, 1);
    checkOutput("latest_b", 1, 32'h4, 1, NOP, 0);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("latest_c", 1, 32'h4, 1, NOP, 0);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("latest_d", 1, 32'h300, 1, instr_at(32'h300), 0);

    $display("[TB] directed phase done, starting random phase");
    m_pc_known = 1'b0;
    ref_step(1, 0, 0, 32'h0, 0, e_chk, e_pc, e_rd, e_ins, e_hld);
    applyStimulus(1, 0, 0, 32'h0, 0);
    checkOutput("rnd_rst", e_chk, e_pc, e_rd, e_ins, e_hld);

    for (int n = 0; n < 3000; n++) begin
      r_rst   = ($urandom_range(0, 99) < 2);
      r_stall = ($urandom_range(0, 99) < 35);
      r_bt    = ($urandom_range(0, 99) < 12);
      r_busy  = ($urandom_range(0, 99) < 40);
      r_tgt   = $urandom();
      ref_step(r_rst, r_stall, r_bt, r_tgt, r_busy, e_chk, e_pc, e_rd, e_ins, e_hld);
      applyStimulus(r_rst, r_stall, r_bt, r_tgt, r_busy);
      checkOutput("rnd", e_chk, e_pc, e_rd, e_ins, e_hld);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
